// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage pipelined adder/subtractor for {sign, exp, frac} mini-floats with hidden 1.
// Define ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.
module fp_addsub_pipe #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 4
) (
  input  logic                  clk50M,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op,
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] sum,
  output logic                  overflow,
  output logic                  zero
);
  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int L   = FRAC_W + 1;   // mantissa including hidden bit
  localparam int AW  = FRAC_W + 4;   // {mantissa, G, R, S}
  localparam int RW  = FRAC_W + 5;   // AW plus carry
  localparam int LZW = $clog2(AW + 1);
  localparam int XW  = ((EXP_W > $clog2(RW)) ? EXP_W : $clog2(RW)) + 2;
  localparam logic [XW-2:0] EMAX = {{(XW-1-EXP_W){1'b0}}, {EXP_W{1'b1}}};

  logic              s1_valid, s1_sign, s1_sub;
  logic [EXP_W-1:0]  s1_exp;
  logic [L-1:0]      s1_big;
  logic [AW-1:0]     s1_sml;
  logic              s2_valid, s2_sign;
  logic [EXP_W-1:0]  s2_exp;
  logic [RW-1:0]     s2_r;
  logic              ld1, ld2, ld3;

  assign ld3      = !out_valid || out_ready;
  assign ld2      = !s2_valid || ld3;
  assign ld1      = !s1_valid || ld2;
  assign in_ready = ld1;

  // S1: magnitude compare, operand swap and alignment of the smaller operand
  logic              sa, sb, a_big, big_s, big_nz, sml_nz;
  logic [EXP_W-1:0]  big_e, sml_e, diff;
  logic [FRAC_W-1:0] big_f, sml_f;
  logic [2*L+1:0]    sml_wide;
  logic [AW-1:0]     sml_al;

  always_comb begin
    sa     = a[W-1];
    sb     = b[W-1] ^ op;
    a_big  = (a[W-2:FRAC_W] > b[W-2:FRAC_W]) ||
             ((a[W-2:FRAC_W] == b[W-2:FRAC_W]) && (a[FRAC_W-1:0] >= b[FRAC_W-1:0]));
    big_s  = a_big ? sa : sb;
    big_e  = a_big ? a[W-2:FRAC_W] : b[W-2:FRAC_W];
    big_f  = a_big ? a[FRAC_W-1:0] : b[FRAC_W-1:0];
    big_nz = a_big ? (|a[W-2:0]) : (|b[W-2:0]);
    sml_e  = a_big ? b[W-2:FRAC_W] : a[W-2:FRAC_W];
    sml_f  = a_big ? b[FRAC_W-1:0] : a[FRAC_W-1:0];
    sml_nz = a_big ? (|b[W-2:0]) : (|a[W-2:0]);
    diff   = big_e - sml_e;
    sml_wide = {sml_nz, sml_f, {(L+2){1'b0}}} >> diff;
    // Beyond R the smaller operand only survives as sticky; no shift-count wrap
    if (32'(diff) > FRAC_W + 2)
      sml_al = {{(AW-1){1'b0}}, sml_nz};
    else
      sml_al = {sml_wide[2*L+1:L], |sml_wide[L-1:0]};
  end

  // S2: effective add or subtract; bigger magnitude is always the minuend
  logic [RW-1:0] s2_next;
  assign s2_next = s1_sub ? ({1'b0, s1_big, 3'b000} - {1'b0, s1_sml})
                          : ({1'b0, s1_big, 3'b000} + {1'b0, s1_sml});

  // S3: normalise, round, then saturate or flush
  logic [LZW-1:0] lz;
  logic [AW-1:0]  norm;
  logic [XW-1:0]  ex_n, ex_f;
  logic [L:0]     mant_r;
  logic [L-1:0]   mant_f;
  logic           rnd_up, res_zero, res_ovf;
  logic [W-1:0]   res;
  logic           unused_bits;

  always_comb begin
    lz = '0;
    for (int i = 0; i < AW; i++)
      if (s2_r[i]) lz = LZW'(AW - 1 - i);
    if (s2_r[RW-1]) begin
      norm = {s2_r[RW-1:2], s2_r[1] | s2_r[0]};
      ex_n = {{(XW-EXP_W){1'b0}}, s2_exp} + XW'(1);
    end else begin
      norm = s2_r[AW-1:0] << lz;
      ex_n = {{(XW-EXP_W){1'b0}}, s2_exp} - {{(XW-LZW){1'b0}}, lz};
    end
`ifdef ROUND_NEAREST_EN
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
    rnd_up = 1'b0;
`endif
    mant_r   = {1'b0, norm[AW-1:3]} + {{L{1'b0}}, rnd_up};
    mant_f   = mant_r[L] ? mant_r[L:1] : mant_r[L-1:0];
    ex_f     = ex_n + {{(XW-1){1'b0}}, mant_r[L]};
    res_zero = (s2_r == '0) || ex_f[XW-1];
    res_ovf  = !res_zero && (ex_f[XW-2:0] > EMAX);
    if (res_zero)
      res = '0;
    else if (res_ovf)
      res = {s2_sign, {(W-1){1'b1}}};
    else
      res = {s2_sign, ex_f[EXP_W-1:0], mant_f[FRAC_W-1:0]};
  end

  assign unused_bits = ^{mant_f[L-1], norm[2:0]};

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_sub    <= 1'b0;
      s1_exp    <= '0;
      s1_big    <= '0;
      s1_sml    <= '0;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_exp    <= '0;
      s2_r      <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (ld1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= big_s;
          s1_sub  <= sa ^ sb;
          s1_exp  <= big_e;
          s1_big  <= {big_nz, big_f};
          s1_sml  <= sml_al;
        end
      end
      if (ld2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sign <= s1_sign;
          s2_exp  <= s1_exp;
          s2_r    <= s2_next;
        end
      end
      if (ld3) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          sum      <= res;
          overflow <= res_ovf;
          zero     <= res_zero;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe (EXP_W=4, FRAC_W=4): directed vectors, backpressure, reset.
// Expected values follow the ROUND_NEAREST_EN setting of the build.
module tb_fp_addsub_pipe;
  localparam int EXP_W  = 4;
  localparam int FRAC_W = 4;
  localparam int W      = 1 + EXP_W + FRAC_W;

  logic         clk50M = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         op = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, overflow, zero;
  logic [W-1:0] sum;

  fp_addsub_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
    .clk50M(clk50M), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk50M = ~clk50M;

  typedef struct packed {
    logic [W-1:0] a, b;
    logic         op;
    logic [W-1:0] s_t, s_r;   // truncating / round-nearest result
    logic         o_t, o_r;
    logic         z;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         ovf;
    logic         zero;
  } resp_t;

  vec_t vecs [18] = '{
    '{9'h030, 9'h030, 1'b0, 9'h040, 9'h040, 1'b0, 1'b0, 1'b0},
    '{9'h048, 9'h030, 1'b1, 9'h040, 9'h040, 1'b0, 1'b0, 1'b0},
    '{9'h055, 9'h055, 1'b1, 9'h000, 9'h000, 1'b0, 1'b0, 1'b1},
    '{9'h0F8, 9'h0F8, 1'b0, 9'h0FF, 9'h0FF, 1'b1, 1'b1, 1'b0},
    '{9'h040, 9'h00F, 1'b0, 9'h041, 9'h042, 1'b0, 1'b0, 1'b0},
    '{9'h000, 9'h135, 1'b1, 9'h035, 9'h035, 1'b0, 1'b0, 1'b0},
    '{9'h123, 9'h000, 1'b0, 9'h123, 9'h123, 1'b0, 1'b0, 1'b0},
    '{9'h030, 9'h130, 1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b1},
    '{9'h020, 9'h030, 1'b1, 9'h120, 9'h120, 1'b0, 1'b0, 1'b0},
    '{9'h011, 9'h010, 1'b1, 9'h000, 9'h000, 1'b0, 1'b0, 1'b1},
    '{9'h051, 9'h050, 1'b1, 9'h010, 9'h010, 1'b0, 1'b0, 1'b0},
    '{9'h03F, 9'h031, 1'b0, 9'h048, 9'h048, 1'b0, 1'b0, 1'b0},
    '{9'h040, 9'h008, 1'b0, 9'h041, 9'h042, 1'b0, 1'b0, 1'b0},
    '{9'h041, 9'h008, 1'b0, 9'h042, 9'h042, 1'b0, 1'b0, 1'b0},
    '{9'h05F, 9'h008, 1'b0, 9'h05F, 9'h060, 1'b0, 1'b0, 1'b0},
    '{9'h0FF, 9'h0A8, 1'b0, 9'h0FF, 9'h0FF, 1'b0, 1'b1, 1'b0},
    '{9'h0F0, 9'h00F, 1'b1, 9'h0EF, 9'h0F0, 1'b0, 1'b0, 1'b0},
    '{9'h0F0, 9'h00F, 1'b0, 9'h0F0, 9'h0F0, 1'b0, 1'b0, 1'b0}
  };

  resp_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    nout = 0;
  logic  rand_rdy = 1'b0;

  function automatic resp_t expect_of(input vec_t v);
    resp_t r;
`ifdef ROUND_NEAREST_EN
    r.sum = v.s_r;
    r.ovf = v.o_r;
`else
    r.sum = v.s_t;
    r.ovf = v.o_t;
`endif
    r.zero = v.z;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic send(input vec_t v);
    int  t;
    logic done;
    t = 0;
    done = 1'b0;
    a = v.a; b = v.b; op = v.op; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk50M);
      if (in_ready) begin
        exp_q.push_back(expect_of(v));
        done = 1'b1;
      end else if (++t > 100) begin
        chk("send_timeout", 32'(in_ready), 32'(1));
        done = 1'b1;
      end
    end
    @(posedge clk50M); #1;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk50M);
      t++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  // Monitor: pops the scoreboard on each transfer and checks output stability while stalled
  initial begin : monitor
    resp_t      e;
    logic       holding;
    logic [W+1:0] held;
    holding = 1'b0;
    held = '0;
    forever begin
      @(negedge clk50M);
      if (rst) begin
        holding = 1'b0;
      end else begin
        if (holding)
          chk("stall_hold", 32'({out_valid, sum, overflow, zero}), 32'({1'b1, held}));
        holding = out_valid && !out_ready;
        held = {sum, overflow, zero};
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'({sum, overflow, zero}), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("result#%0d", nout), 32'({sum, overflow, zero}), 32'(e));
            nout++;
          end
        end
      end
    end
  end

  initial begin : ready_randomiser
    forever begin
      @(posedge clk50M); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k, c, lat;
    repeat (3) @(posedge clk50M);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    rst = 1'b0;
    @(negedge clk50M);
    chk("post_rst_in_ready", 32'(in_ready), 32'(1));
    chk("post_rst_overflow", 32'(overflow), 32'(0));
    chk("post_rst_zero", 32'(zero), 32'(0));
    @(posedge clk50M); #1;

    // Directed vectors, back-to-back with the consumer always ready
    out_ready = 1'b1;
    foreach (vecs[i]) send(vecs[i]);
    in_valid = 1'b0;
    wait_drain();

    // Latency from accept edge to out_valid
    @(posedge clk50M); #1;
    send(vecs[0]);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk50M); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(3));
    wait_drain();

    // Backpressure: consumer stalled for 6 cycles while 5 beats are offered
    @(posedge clk50M); #1;
    out_ready = 1'b0;
    k = 0;
    for (int cy = 0; cy < 6; cy++) begin
      in_valid = 1'b1;
      a = vecs[k].a; b = vecs[k].b; op = vecs[k].op;
      @(negedge clk50M);
      if (in_ready) begin
        exp_q.push_back(expect_of(vecs[k]));
        k++;
      end
      @(posedge clk50M); #1;
    end
    @(negedge clk50M);
    chk("bp_in_ready", 32'(in_ready), 32'(0));
    chk("bp_accepted", 32'(k), 32'(3));
    @(posedge clk50M); #1;
    out_ready = 1'b1;
    c = 0;
    while ((k < 5 || c < 3) && c < 30) begin
      in_valid = (k < 5);
      if (k < 5) begin
        a = vecs[k].a; b = vecs[k].b; op = vecs[k].op;
      end
      @(negedge clk50M);
      if (c < 3) chk($sformatf("bp_drain_cycle%0d", c), 32'(out_valid), 32'(1));
      if (in_valid && in_ready) begin
        exp_q.push_back(expect_of(vecs[k]));
        k++;
      end
      @(posedge clk50M); #1;
      c++;
    end
    in_valid = 1'b0;
    chk("bp_accept_all", 32'(k), 32'(5));
    wait_drain();

    // Back-to-back stream with a randomly stalling consumer
    @(posedge clk50M); #1;
    rand_rdy = 1'b1;
    for (int p = 0; p < 2; p++)
      foreach (vecs[i]) send(vecs[i]);
    in_valid = 1'b0;
    wait_drain();
    rand_rdy = 1'b0;
    @(posedge clk50M); #2;
    out_ready = 1'b1;

    // Reset with beats in flight
    out_ready = 1'b0;
    send(vecs[0]);
    send(vecs[1]);
    send(vecs[2]);
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'(1));
    chk("pre_rst_sum", 32'(sum), 32'(9'h040));
    @(negedge clk50M); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_sum", 32'(sum), 32'(0));
    chk("mid_rst_flags", 32'({overflow, zero}), 32'(0));
    exp_q.delete();
    @(negedge clk50M);
    @(posedge clk50M); #1;
    rst = 1'b0;
    @(negedge clk50M);
    chk("rel_in_ready", 32'(in_ready), 32'(1));
    chk("rel_out_valid", 32'(out_valid), 32'(0));
    @(posedge clk50M); #1;
    out_ready = 1'b1;
    send(vecs[15]);
    in_valid = 1'b0;
    wait_drain();
    repeat (3) @(posedge clk50M);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
